// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the two-master Wishbone arbiter.
package wb_arb_pkg;

    localparam int ADDR_WIDTH_DEF     = 32;
    localparam int DATA_WIDTH_DEF     = 32;
    localparam int TIMEOUT_CYCLES_DEF = 255;
    localparam int TIMEOUT_W_DEF      = 8;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_M0 = 2'd1,
        GNT_M1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/wb_arb_timeout.sv
// Stall counter for the granted master: flags a hung strobe and remembers that it happened.
module wb_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic stb,
    input  logic ack,
    output logic expire,
    output logic sticky
);

    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

    logic [TIMEOUT_W-1:0] count;

    // An ack landing in the limit cycle completes the transfer instead of erroring.
    assign expire = (TIMEOUT_CYCLES != 0) && active && stb && !ack && (count == LIMIT);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            sticky <= 1'b0;
        end else begin
            if (!active || !stb || ack || expire) begin
                count <= '0;
            end else begin
                count <= count + TIMEOUT_W'(1);
            end
            if (expire) begin
                sticky <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_dual_master_arbiter.sv
// Round-robin classic Wishbone arbiter merging a read-only ibus (M0) and a dbus (M1)
// onto one slave port, with grant locking per cyc and a stall timeout.
module wb_dual_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int SEL_WIDTH      = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int TIMEOUT_W      = TIMEOUT_W_DEF
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    input  logic [SEL_WIDTH-1:0]  m1_sel_i,
    input  logic                  m1_we_i,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    output logic [SEL_WIDTH-1:0]  s_sel_o,
    output logic                  s_we_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    output logic                  timeout_o,
    output logic [1:0]            grant_o
);

    arb_state_e state;
    logic       last_grant;
    logic       gnt_stb;
    logic       expire;

    assign gnt_stb = (state == GNT_M0) ? (m0_cyc_i & m0_stb_i) :
                     (state == GNT_M1) ? (m1_cyc_i & m1_stb_i) : 1'b0;

    wb_arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_timeout (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .active (state != IDLE),
        .stb    (gnt_stb),
        .ack    (s_ack_i),
        .expire (expire),
        .sticky (timeout_o)
    );

    // On a tie the master that did not hold the last grant wins.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            last_grant <= M1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || last_grant == M1)) begin
                        state      <= GNT_M0;
                        last_grant <= M0;
                    end else if (m1_cyc_i) begin
                        state      <= GNT_M1;
                        last_grant <= M1;
                    end
                end
                GNT_M0:  if (expire || !m0_cyc_i) state <= IDLE;
                GNT_M1:  if (expire || !m1_cyc_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign grant_o  = {state == GNT_M1, state == GNT_M0};
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        case (state)
            GNT_M0: begin
                s_adr_o  = m0_adr_i;
                s_sel_o  = '1;
                s_cyc_o  = m0_cyc_i & ~expire;
                s_stb_o  = m0_stb_i & ~expire;
                m0_ack_o = s_ack_i;
                m0_err_o = expire;
            end
            GNT_M1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i & ~expire;
                s_stb_o  = m1_stb_i & ~expire;
                m1_ack_o = s_ack_i;
                m1_err_o = expire;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Self-checking bench: directed vector table, hand sequences for timeout/lock/reset,
// and a randomized run against a transaction-level reference model.
module tb_wb_dual_master_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] m0_adr, m1_adr, s_adr;
    logic [DW-1:0] m0_dat, m1_dat_i, m1_dat, s_dat_o, s_dat_i;
    logic [SW-1:0] m1_sel, s_sel;
    logic          m0_cyc, m0_stb, m0_ack, m0_err;
    logic          m1_we, m1_cyc, m1_stb, m1_ack, m1_err;
    logic          s_we, s_cyc, s_stb, s_ack, timeout;
    logic [1:0]    grant;

    always #5 clk = ~clk;

    wb_dual_master_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW),
        .TIMEOUT_CYCLES(TO), .TIMEOUT_W(8)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_adr_i(m0_adr), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
        .m0_dat_o(m0_dat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
        .m1_dat_o(m1_dat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_sel_o(s_sel), .s_we_o(s_we),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_dat_i(s_dat_i), .s_ack_i(s_ack),
        .timeout_o(timeout), .grant_o(grant)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ctl(input string tag, input logic [1:0] g,
                              input logic sc, input logic ss, input logic a0, input logic a1,
                              input logic r0, input logic r1, input logic to_flag);
        check({tag, " grant"}, grant, g);
        check({tag, " {cyc,stb,ack0,ack1,err0,err1,timeout}"},
              {s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err, timeout},
              {sc, ss, a0, a1, r0, r1, to_flag});
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic c0, input logic s0, input logic c1, input logic s1,
                         input logic ack);
        @(negedge clk);
        m0_cyc = c0; m0_stb = s0; m1_cyc = c1; m1_stb = s1; s_ack = ack;
        #1;
    endtask

    typedef struct {
        logic       c0, s0, c1, s1, we, ack;
        logic [1:0] grant;
        logic       scyc, sstb, swe, a0, a1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic c0, input logic s0, input logic c1, input logic s1,
                                input logic we, input logic ack, input logic [1:0] g,
                                input logic sc, input logic ss, input logic swe,
                                input logic a0, input logic a1);
        vec_t v;
        v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.we = we; v.ack = ack;
        v.grant = g; v.scyc = sc; v.sstb = ss; v.swe = swe; v.a0 = a0; v.a1 = a1;
        return v;
    endfunction

    // Reference model state: owner -1 = idle, otherwise master index.
    int   owner, last, stall;
    bit   sticky, expire, mc, ms;
    logic [1:0]    e_grant;
    logic          e_cyc, e_stb, e_we, e_a0, e_a1, e_r0, e_r1;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [SW-1:0] e_sel;

    initial begin
        rst = 1'b1;
        m0_adr = 32'h0000_0100; m0_cyc = 0; m0_stb = 0;
        m1_adr = 32'h0000_1000; m1_dat_i = 32'hCAFE_BABE; m1_sel = 4'b0011;
        m1_we = 0; m1_cyc = 0; m1_stb = 0;
        s_dat_i = 32'h0000_0013; s_ack = 0;

        // Tie + round-robin, ack in IDLE ignored, M0 read, M1 write.
        tbl.push_back(mk(1,1,1,1,1,0, 2'b00,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,1,1,0, 2'b01,1,1,0,0,0));
        tbl.push_back(mk(1,1,1,1,1,1, 2'b01,1,1,0,1,0));
        tbl.push_back(mk(0,0,1,1,1,0, 2'b01,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,1,1,0, 2'b00,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,1,1,1, 2'b10,1,1,1,0,1));
        tbl.push_back(mk(1,1,0,0,0,0, 2'b10,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0,0, 2'b00,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0,1, 2'b01,1,1,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0, 2'b01,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1, 2'b00,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0,0, 2'b00,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0,0, 2'b01,1,1,0,0,0));
        tbl.push_back(mk(1,1,0,0,0,0, 2'b01,1,1,0,0,0));
        tbl.push_back(mk(1,1,0,0,0,1, 2'b01,1,1,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0, 2'b01,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 2'b00,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,1,1,0, 2'b00,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,1,1,0, 2'b10,1,1,1,0,0));
        tbl.push_back(mk(0,0,1,1,1,1, 2'b10,1,1,1,0,1));
        tbl.push_back(mk(0,0,0,0,0,0, 2'b10,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 2'b00,0,0,0,0,0));

        #2;
        expect_ctl("reset", 2'b00, 0, 0, 0, 0, 0, 0, 0);
        check("reset s_bus", {s_adr, s_sel, s_dat_o, s_we}, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            m0_cyc = tbl[i].c0; m0_stb = tbl[i].s0; m1_cyc = tbl[i].c1; m1_stb = tbl[i].s1;
            m1_we = tbl[i].we; s_ack = tbl[i].ack;
            #1;
            expect_ctl($sformatf("tbl[%0d]", i), tbl[i].grant, tbl[i].scyc, tbl[i].sstb,
                       tbl[i].a0, tbl[i].a1, 0, 0, 0);
            check($sformatf("tbl[%0d] s_we", i), s_we, tbl[i].swe);
            if (tbl[i].grant == 2'b01)
                check($sformatf("tbl[%0d] bus", i), {s_adr, s_sel, s_dat_o}, {32'h100, 4'hF, 32'h0});
            else if (tbl[i].grant == 2'b10)
                check($sformatf("tbl[%0d] bus", i), {s_adr, s_sel, s_dat_o}, {32'h1000, 4'h3, 32'hCAFEBABE});
            else
                check($sformatf("tbl[%0d] bus", i), {s_adr, s_sel, s_dat_o}, '0);
            check($sformatf("tbl[%0d] rdata", i), {m0_dat, m1_dat}, {32'h13, 32'h13});
        end

        // M1 locks the bus for three beats while M0 waits.
        m1_we = 1'b0;
        drive(0,0,1,1,0);  expect_ctl("lock idle", 2'b00, 0, 0, 0, 0, 0, 0, 0);
        for (int b = 0; b < 3; b++) begin
            drive(1,1,1,1,1);
            expect_ctl($sformatf("lock beat%0d", b), 2'b10, 1, 1, 0, 1, 0, 0, 0);
        end
        drive(1,1,0,0,0);  expect_ctl("lock release", 2'b10, 0, 0, 0, 0, 0, 0, 0);
        drive(1,1,0,0,0);  expect_ctl("lock gap", 2'b00, 0, 0, 0, 0, 0, 0, 0);
        drive(1,1,0,0,1);  expect_ctl("lock m0 gnt", 2'b01, 1, 1, 1, 0, 0, 0, 0);
        drive(0,0,0,0,0);
        drive(0,0,0,0,0);

        // Ack arriving in the would-be timeout cycle wins and clears the counter.
        drive(1,1,0,0,0);  expect_ctl("race idle", 2'b00, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < TO; k++) begin
            drive(1,1,0,0,0);
            expect_ctl($sformatf("race stall%0d", k), 2'b01, 1, 1, 0, 0, 0, 0, 0);
        end
        drive(1,1,0,0,1);  expect_ctl("race ack", 2'b01, 1, 1, 1, 0, 0, 0, 0);
        for (int k = 0; k < TO; k++) begin
            drive(1,1,0,0,0);
            expect_ctl($sformatf("race restall%0d", k), 2'b01, 1, 1, 0, 0, 0, 0, 0);
        end
        drive(0,0,0,0,0);  expect_ctl("race release", 2'b01, 0, 0, 0, 0, 0, 0, 0);
        drive(0,0,0,0,0);  expect_ctl("race after", 2'b00, 0, 0, 0, 0, 0, 0, 0);

        // Slave never acks: err on the fifth stalled cycle, then sticky flag.
        drive(1,1,0,0,0);  expect_ctl("tmo idle", 2'b00, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < TO; k++) begin
            drive(1,1,0,0,0);
            expect_ctl($sformatf("tmo stall%0d", k), 2'b01, 1, 1, 0, 0, 0, 0, 0);
        end
        drive(1,1,0,0,0);
        check("tmo expire grant", grant, 2'b01);
        check("tmo expire {cyc,stb,ack0,err0,err1}", {s_cyc, s_stb, m0_ack, m0_err, m1_err}, 5'b00010);
        drive(0,0,0,0,0);  expect_ctl("tmo after", 2'b00, 0, 0, 0, 0, 0, 0, 1);
        drive(0,0,0,0,0);  expect_ctl("tmo sticky", 2'b00, 0, 0, 0, 0, 0, 0, 1);

        // Asynchronous reset in the middle of an M1 cycle.
        drive(0,0,1,1,0);
        drive(0,0,1,1,1);  expect_ctl("rst pre", 2'b10, 1, 1, 0, 1, 0, 0, 1);
        #2 rst = 1'b1;
        #1 expect_ctl("rst async", 2'b00, 0, 0, 0, 0, 0, 0, 0);
        drive(0,0,0,0,0);
        drive(0,0,0,0,0);
        rst = 1'b0;
        drive(0,0,0,0,0);  expect_ctl("rst released", 2'b00, 0, 0, 0, 0, 0, 0, 0);

        // Randomized run against the reference model, starting from reset state.
        owner = -1; last = 1; stall = 0; sticky = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (m0_cyc) m0_cyc = ($urandom_range(3) != 0);
            else        m0_cyc = ($urandom_range(2) == 0);
            if (m1_cyc) m1_cyc = ($urandom_range(3) != 0);
            else        m1_cyc = ($urandom_range(2) == 0);
            m0_stb = m0_cyc & ($urandom_range(3) != 0);
            m1_stb = m1_cyc & ($urandom_range(3) != 0);
            m0_adr = $urandom; m1_adr = $urandom; m1_dat_i = $urandom;
            m1_sel = 4'($urandom); m1_we = 1'($urandom); s_dat_i = $urandom;
            s_ack  = ($urandom_range(2) == 0);

            e_grant = '0; e_cyc = 0; e_stb = 0; e_we = 0; e_a0 = 0; e_a1 = 0; e_r0 = 0; e_r1 = 0;
            e_adr = '0; e_dat = '0; e_sel = '0; expire = 0;
            if (owner >= 0) begin
                mc = (owner == 0) ? m0_cyc : m1_cyc;
                ms = (owner == 0) ? m0_stb : m1_stb;
                expire  = mc && ms && !s_ack && (stall == TO);
                e_grant = (owner == 0) ? 2'b01 : 2'b10;
                e_cyc   = mc && !expire;
                e_stb   = ms && !expire;
                e_adr   = (owner == 0) ? m0_adr : m1_adr;
                e_sel   = (owner == 0) ? 4'hF : m1_sel;
                e_dat   = (owner == 0) ? '0 : m1_dat_i;
                e_we    = (owner == 1) && m1_we;
                e_a0    = (owner == 0) && s_ack;
                e_a1    = (owner == 1) && s_ack;
                e_r0    = (owner == 0) && expire;
                e_r1    = (owner == 1) && expire;
            end
            #1;
            expect_ctl($sformatf("rnd[%0d]", n), e_grant, e_cyc, e_stb, e_a0, e_a1, e_r0, e_r1, sticky);
            check($sformatf("rnd[%0d] bus", n), {s_adr, s_sel, s_dat_o, s_we}, {e_adr, e_sel, e_dat, e_we});
            check($sformatf("rnd[%0d] rdata", n), {m0_dat, m1_dat}, {s_dat_i, s_dat_i});

            if (owner < 0) begin
                if (m0_cyc && m1_cyc) owner = 1 - last;
                else if (m0_cyc)      owner = 0;
                else if (m1_cyc)      owner = 1;
                if (owner >= 0) last = owner;
            end else if (expire) begin
                sticky = 1; owner = -1; stall = 0;
            end else if (!mc) begin
                owner = -1; stall = 0;
            end else begin
                stall = (ms && !s_ack) ? stall + 1 : 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
